stream_merge_arbiter: RTL and testbench
=======================================

Name: stream_merge_arbiter

Overview:
- Packet-atomic round-robin arbiter that merges NUM_SOURCES forward-path streams onto one forward-path interface. Typical load: several PEs sharing a single TurnAround or downstream link.
- Once a source wins, it owns the output until its Last beat has transferred, so packets are never interleaved.
- Output is registered: one stage, 1-cycle latency. Backpressure comes from out_Ready.

Parameters:
- NUM_SOURCES, 4, number of merged sources (2..16).
- DATA_WIDTH, 512, payload width; multiple of 32.
- STREAM_ID_WIDTH, 4, width of StreamID.
- CHUNK_ID_WIDTH, 5, width of ChunkID.
- CHANNEL_ID_WIDTH, 10, width of ChannelID.
- STATE_WIDTH, 32, width of State.
- IDX_WIDTH, $clog2(NUM_SOURCES), width of the source index.

Ports:
- clk  in  1  single clock.
- rstIn  in  1  asynchronous, active-high reset.
- src_Data  in  NUM_SOURCES*DATA_WIDTH  source i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]; other bundles are sliced the same way.
- src_Type  in  NUM_SOURCES*2  per-source beat type; 0 = no beat.
- src_Last  in  NUM_SOURCES  per-source last beat of packet.
- src_StreamID  in  NUM_SOURCES*STREAM_ID_WIDTH
- src_ChunkID  in  NUM_SOURCES*CHUNK_ID_WIDTH
- src_ChannelID  in  NUM_SOURCES*CHANNEL_ID_WIDTH
- src_State  in  NUM_SOURCES*STATE_WIDTH
- src_Ready  out  NUM_SOURCES  per-source accept; combinational.
- out_Data  out  DATA_WIDTH  registered.
- out_Type  out  2  registered; 0 = output register empty.
- out_Last  out  1  registered.
- out_StreamID, out_ChunkID, out_ChannelID, out_State  out  (parameter widths)  registered.
- out_SourceIdx  out  IDX_WIDTH  source of the beat currently held in the output register.
- out_Ready  in  1  downstream accepts the beat held in the output register.

Behaviour:
- Beat valid on source i when src_Type[i] != 0. A transfer occurs when the beat is valid and src_Ready[i] = 1.
- Output transfer occurs when out_Type != 0 and out_Ready = 1.
- can_load = (out_Type == 0) | out_Ready.
- src_Ready[i] = can_load & (i == selected source). At most one bit is set.
- Selected source:
  - LOCKED: selected = owner.
  - IDLE: selected = first source with a valid beat, searching round-robin from ptr+1 mod NUM_SOURCES.
  - IDLE with no valid source: none selected.
- On a source transfer:
  - Output register loads all fields from that source; out_SourceIdx = source index.
  - Type is passed through unchanged.
- If can_load and there is no source transfer, out_Type <= 0. Other output fields hold their values (don't-care).
- Output register holds unchanged while out_Type != 0 and out_Ready = 0.
- State machine:
  - IDLE, transfer with Last = 0 -> LOCKED, owner = source.
  - IDLE, transfer with Last = 1 -> stay IDLE, ptr = source (single-beat packet).
  - LOCKED, owner transfer with Last = 1 -> IDLE, ptr = owner.
  - LOCKED otherwise -> stay LOCKED.
  - Owner Type == 0 (gap mid-packet): stay LOCKED; other sources are blocked. There is no timeout.
- ptr updates only at packet end, so arbitration is fair per packet, not per beat.
- Latency: a source beat appears on the outputs the cycle after its transfer. Full throughput is 1 beat/cycle when out_Ready is held high.
- Reset (rstIn high, asynchronous): state = IDLE, ptr = NUM_SOURCES-1 (source 0 has first priority), owner = 0. All out_* = 0, including out_Type = 0. src_Ready = 0 while reset is asserted.
- Reset mid-packet: the lock is dropped and the held beat is discarded. Upstream is reset by the same rstIn.
- Simultaneous events in one cycle: an output transfer and a new source load are both legal. The register is replaced, with no bubble.
- A source with Type != 0 but not selected must hold its beat; the arbiter never drops beats.

Test Plan:
- Reset, then sources 0 and 2 each present a 1-beat packet (Type = 1, Last = 1), out_Ready = 1 -> out_SourceIdx = 0 at cycle 1, then 2 at cycle 2, then out_Type = 0.
- Source 1 sends a 3-beat packet while source 3 is valid the whole time -> source 1's three beats appear contiguously. Source 3 has src_Ready = 0 until the cycle after source 1's Last transfer, then its beat appears.
- All 4 sources continuously valid, 1-beat packets -> output order 0,1,2,3,0,1...; no source is granted twice before the others.
- out_Ready = 0 for 5 cycles with a beat held -> outputs stable and all src_Ready = 0. When out_Ready rises, the next beat loads the same cycle with no bubble.
- Owner source 0 drops Type to 0 for 2 cycles mid-packet while source 1 is valid -> state stays LOCKED, src_Ready[1] = 0, and the packet resumes from source 0.
- rstIn pulsed asynchronously mid-packet (between clock edges) -> out_Type = 0 immediately. After release, source 0 has priority over a pending source 3.

Source files
------------

// File: rtl/stream_merge_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stream_merge_arbiter
// Brief    : Packet-atomic round-robin merge of NUM_SOURCES streams onto one
//            registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
module stream_merge_arbiter #(
    parameter int NUM_SOURCES      = 4,
    parameter int DATA_WIDTH       = 512,
    parameter int STREAM_ID_WIDTH  = 4,
    parameter int CHUNK_ID_WIDTH   = 5,
    parameter int CHANNEL_ID_WIDTH = 10,
    parameter int STATE_WIDTH      = 32,
    parameter int IDX_WIDTH        = $clog2(NUM_SOURCES)
) (
    input  logic                                   clk,
    input  logic                                   rstIn,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0]       src_Data,
    input  logic [NUM_SOURCES*2-1:0]                src_Type,
    input  logic [NUM_SOURCES-1:0]                  src_Last,
    input  logic [NUM_SOURCES*STREAM_ID_WIDTH-1:0]  src_StreamID,
    input  logic [NUM_SOURCES*CHUNK_ID_WIDTH-1:0]   src_ChunkID,
    input  logic [NUM_SOURCES*CHANNEL_ID_WIDTH-1:0] src_ChannelID,
    input  logic [NUM_SOURCES*STATE_WIDTH-1:0]      src_State,
    output logic [NUM_SOURCES-1:0]                  src_Ready,
    output logic [DATA_WIDTH-1:0]                   out_Data,
    output logic [1:0]                              out_Type,
    output logic                                    out_Last,
    output logic [STREAM_ID_WIDTH-1:0]              out_StreamID,
    output logic [CHUNK_ID_WIDTH-1:0]               out_ChunkID,
    output logic [CHANNEL_ID_WIDTH-1:0]             out_ChannelID,
    output logic [STATE_WIDTH-1:0]                  out_State,
    output logic [IDX_WIDTH-1:0]                    out_SourceIdx,
    input  logic                                    out_Ready
);

    localparam logic [0:0]           c_IDLE     = 1'b0;
    localparam logic [0:0]           c_LOCKED   = 1'b1;
    localparam logic [IDX_WIDTH-1:0] c_LAST_IDX = IDX_WIDTH'(NUM_SOURCES - 1);

    logic [0:0]            r_state;
    logic [0:0]            w_stateNext;
    logic [IDX_WIDTH-1:0]  r_ptr;
    logic [IDX_WIDTH-1:0]  w_ptrNext;
    logic [IDX_WIDTH-1:0]  r_owner;
    logic [IDX_WIDTH-1:0]  w_ownerNext;
    logic [IDX_WIDTH-1:0]  w_sel;
    logic                  w_selActive;
    logic                  w_canLoad;
    logic                  w_srcXfer;
    logic [NUM_SOURCES-1:0] w_valid;

    logic [DATA_WIDTH-1:0]       w_data    [NUM_SOURCES];
    logic [1:0]                  w_type    [NUM_SOURCES];
    logic [STREAM_ID_WIDTH-1:0]  w_stream  [NUM_SOURCES];
    logic [CHUNK_ID_WIDTH-1:0]   w_chunk   [NUM_SOURCES];
    logic [CHANNEL_ID_WIDTH-1:0] w_channel [NUM_SOURCES];
    logic [STATE_WIDTH-1:0]      w_stateIn [NUM_SOURCES];

    generate
        for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_unpack
            assign w_data[gi]    = src_Data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_type[gi]    = src_Type[gi*2 +: 2];
            assign w_stream[gi]  = src_StreamID[gi*STREAM_ID_WIDTH +: STREAM_ID_WIDTH];
            assign w_chunk[gi]   = src_ChunkID[gi*CHUNK_ID_WIDTH +: CHUNK_ID_WIDTH];
            assign w_channel[gi] = src_ChannelID[gi*CHANNEL_ID_WIDTH +: CHANNEL_ID_WIDTH];
            assign w_stateIn[gi] = src_State[gi*STATE_WIDTH +: STATE_WIDTH];
            assign w_valid[gi]   = |src_Type[gi*2 +: 2];
        end
    endgenerate

    // Source index k steps after base, wrapping at NUM_SOURCES.
    function automatic logic [IDX_WIDTH-1:0] rrIndex(input logic [IDX_WIDTH-1:0] base,
                                                     input int k);
        return IDX_WIDTH'((int'(base) + k) % NUM_SOURCES);
    endfunction

    assign w_canLoad = (out_Type == 2'd0) | out_Ready;
    assign w_srcXfer = w_selActive & w_canLoad & w_valid[w_sel];

    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            r_state <= c_IDLE;
            r_ptr   <= c_LAST_IDX;
            r_owner <= '0;
        end else begin
            r_state <= w_stateNext;
            r_ptr   <= w_ptrNext;
            r_owner <= w_ownerNext;
        end
    end

    // While locked w_sel is the owner, so a non-last beat simply re-asserts it.
    always_comb begin
        w_stateNext = r_state;
        w_ptrNext   = r_ptr;
        w_ownerNext = r_owner;
        if (w_srcXfer) begin
            if (src_Last[w_sel]) begin
                w_stateNext = c_IDLE;
                w_ptrNext   = w_sel;
            end else begin
                w_stateNext = c_LOCKED;
                w_ownerNext = w_sel;
            end
        end
    end

    // Descending scan so the nearest valid source after r_ptr is written last.
    always_comb begin
        w_sel       = r_owner;
        w_selActive = 1'b0;
        if (r_state == c_LOCKED) begin
            w_sel       = r_owner;
            w_selActive = 1'b1;
        end else begin
            for (int k = NUM_SOURCES; k >= 1; k--) begin
                if (w_valid[rrIndex(r_ptr, k)]) begin
                    w_sel       = rrIndex(r_ptr, k);
                    w_selActive = 1'b1;
                end
            end
        end
        src_Ready = '0;
        if (!rstIn && w_canLoad && w_selActive) begin
            src_Ready[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            out_Data      <= '0;
            out_Type      <= '0;
            out_Last      <= 1'b0;
            out_StreamID  <= '0;
            out_ChunkID   <= '0;
            out_ChannelID <= '0;
            out_State     <= '0;
            out_SourceIdx <= '0;
        end else if (w_canLoad) begin
            if (w_srcXfer) begin
                out_Data      <= w_data[w_sel];
                out_Type      <= w_type[w_sel];
                out_Last      <= src_Last[w_sel];
                out_StreamID  <= w_stream[w_sel];
                out_ChunkID   <= w_chunk[w_sel];
                out_ChannelID <= w_channel[w_sel];
                out_State     <= w_stateIn[w_sel];
                out_SourceIdx <= w_sel;
            end else begin
                out_Type <= 2'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_merge_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_merge_arbiter
// Brief    : Directed scenarios plus randomized traffic against a packet-level
//            reference model of stream_merge_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_merge_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;

    typedef struct {
        logic [1:0]  typ;
        logic        last;
        logic [31:0] data;
        logic [3:0]  sid;
        logic [4:0]  cid;
        logic [9:0]  chid;
        logic [31:0] st;
    } beat_t;

    logic             clk;
    logic             rstIn;
    logic [NS*DW-1:0] src_Data;
    logic [NS*2-1:0]  src_Type;
    logic [NS-1:0]    src_Last;
    logic [NS*4-1:0]  src_StreamID;
    logic [NS*5-1:0]  src_ChunkID;
    logic [NS*10-1:0] src_ChannelID;
    logic [NS*32-1:0] src_State;
    logic [NS-1:0]    src_Ready;
    logic [DW-1:0]    out_Data;
    logic [1:0]       out_Type;
    logic             out_Last;
    logic [3:0]       out_StreamID;
    logic [4:0]       out_ChunkID;
    logic [9:0]       out_ChannelID;
    logic [31:0]      out_State;
    logic [1:0]       out_SourceIdx;
    logic             out_Ready;

    stream_merge_arbiter #(
        .NUM_SOURCES(NS), .DATA_WIDTH(DW), .STREAM_ID_WIDTH(4),
        .CHUNK_ID_WIDTH(5), .CHANNEL_ID_WIDTH(10), .STATE_WIDTH(32), .IDX_WIDTH(2)
    ) dut (
        .clk(clk), .rstIn(rstIn),
        .src_Data(src_Data), .src_Type(src_Type), .src_Last(src_Last),
        .src_StreamID(src_StreamID), .src_ChunkID(src_ChunkID),
        .src_ChannelID(src_ChannelID), .src_State(src_State), .src_Ready(src_Ready),
        .out_Data(out_Data), .out_Type(out_Type), .out_Last(out_Last),
        .out_StreamID(out_StreamID), .out_ChunkID(out_ChunkID),
        .out_ChannelID(out_ChannelID), .out_State(out_State),
        .out_SourceIdx(out_SourceIdx), .out_Ready(out_Ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t src [NS];
    int    rem [NS];
    beat_t mOut;
    int    mOutIdx;
    int    mOwner;
    int    mLastServed;
    int    lastXfer;
    int    total;
    int    bad;

    function automatic beat_t mk(input logic [1:0] t, input logic l, input logic [31:0] d);
        beat_t b;
        b.typ  = t;
        b.last = l;
        b.data = d;
        b.sid  = 4'($urandom);
        b.cid  = 5'($urandom);
        b.chid = 10'($urandom);
        b.st   = $urandom;
        return b;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Who may transfer now: the packet owner, else the first valid source after the last served one.
    function automatic int grantOf();
        if (mOwner >= 0) return mOwner;
        for (int k = 1; k <= NS; k++) begin
            int j = (mLastServed + k) % NS;
            if (src[j].typ != 2'd0) return j;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mOut        = mk(2'd0, 1'b0, 32'd0);
        mOutIdx     = 0;
        mOwner      = -1;
        mLastServed = NS - 1;
        for (int i = 0; i < NS; i++) begin
            src[i] = mk(2'd0, 1'b0, 32'd0);
            rem[i] = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            src_Type[i*2 +: 2]       = src[i].typ;
            src_Last[i]              = src[i].last;
            src_Data[i*DW +: DW]     = src[i].data;
            src_StreamID[i*4 +: 4]   = src[i].sid;
            src_ChunkID[i*5 +: 5]    = src[i].cid;
            src_ChannelID[i*10 +: 10] = src[i].chid;
            src_State[i*32 +: 32]    = src[i].st;
        end
    endtask

    task automatic checkOut();
        check("outType", 64'(out_Type), 64'(mOut.typ));
        if (mOut.typ != 2'd0) begin
            check("outData", 64'(out_Data), 64'(mOut.data));
            check("outMeta",
                  64'({out_Last, out_StreamID, out_ChunkID, out_ChannelID, out_State, out_SourceIdx}),
                  64'({mOut.last, mOut.sid, mOut.cid, mOut.chid, mOut.st, 2'(mOutIdx)}));
        end
    endtask

    // One clock: called at a negedge, returns at the next negedge.
    task automatic step();
        int            g;
        logic          cl;
        logic [NS-1:0] expRdy;
        drive();
        #1;
        g  = grantOf();
        cl = (mOut.typ == 2'd0) || out_Ready;
        expRdy = '0;
        if (cl && g >= 0) expRdy[g] = 1'b1;
        check("srcReady", 64'(src_Ready), 64'(expRdy));
        lastXfer = -1;
        if (cl && g >= 0 && src[g].typ != 2'd0) begin
            mOut     = src[g];
            mOutIdx  = g;
            lastXfer = g;
            if (src[g].last) begin
                mOwner      = -1;
                mLastServed = g;
            end else begin
                mOwner = g;
            end
        end else if (cl) begin
            mOut.typ = 2'd0;
        end
        @(posedge clk);
        #1;
        checkOut();
        if (lastXfer >= 0) src[lastXfer].typ = 2'd0;
        @(negedge clk);
    endtask

    task automatic expectReady(input string tag, input logic [NS-1:0] exp);
        drive();
        #1;
        check(tag, 64'(src_Ready), 64'(exp));
    endtask

    task automatic doReset();
        rstIn = 1'b1;
        modelReset();
        src[1] = mk(2'd1, 1'b1, 32'h0000_00EE);
        drive();
        @(posedge clk);
        #1;
        check("rstReady", 64'(src_Ready), 64'd0);
        check("rstType", 64'(out_Type), 64'd0);
        check("rstFields", 64'({out_Last, out_SourceIdx, out_StreamID, out_ChunkID}), 64'd0);
        check("rstData", 64'(out_Data), 64'd0);
        @(negedge clk);
        rstIn = 1'b0;
        modelReset();
    endtask

    task automatic refresh(input int i);
        if (src[i].typ == 2'd0) begin
            if (rem[i] == 0 && $urandom_range(0, 2) == 0) rem[i] = $urandom_range(1, 4);
            if (rem[i] > 0 && $urandom_range(0, 4) != 0)
                src[i] = mk(2'($urandom_range(1, 3)), rem[i] == 1, $urandom);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        out_Ready = 1'b1;
        rstIn     = 1'b1;
        modelReset();
        drive();

        // Two single-beat packets from sources 0 and 2.
        doReset();
        src[0] = mk(2'd1, 1'b1, 32'hA000_0000);
        src[2] = mk(2'd1, 1'b1, 32'hA000_0002);
        step(); check("t1first", 64'(out_SourceIdx), 64'd0);
        step(); check("t1second", 64'(out_SourceIdx), 64'd2);
        step(); check("t1empty", 64'(out_Type), 64'd0);

        // Three-beat packet from source 1 blocks a waiting source 3.
        doReset();
        src[1] = mk(2'd1, 1'b0, 32'h11);
        src[3] = mk(2'd2, 1'b1, 32'h33);
        expectReady("t2rdyA", 4'b0010); step(); check("t2dataA", 64'(out_Data), 64'h11);
        src[1] = mk(2'd1, 1'b0, 32'h12);
        expectReady("t2rdyB", 4'b0010); step(); check("t2dataB", 64'(out_Data), 64'h12);
        src[1] = mk(2'd1, 1'b1, 32'h13);
        expectReady("t2rdyC", 4'b0010); step(); check("t2dataC", 64'(out_Data), 64'h13);
        expectReady("t2rdyD", 4'b1000); step();
        check("t2src3", 64'({out_SourceIdx, out_Data}), 64'({2'd3, 32'h33}));

        // All sources always valid: strict rotation.
        doReset();
        for (int i = 0; i < NS; i++) src[i] = mk(2'd1, 1'b1, 32'(i));
        for (int k = 0; k < 8; k++) begin
            step();
            check("t3order", 64'(out_SourceIdx), 64'(k % NS));
            if (lastXfer >= 0) src[lastXfer] = mk(2'd1, 1'b1, 32'(lastXfer + 16 * k));
        end

        // Backpressure: held beat stays put, next one loads without a bubble.
        doReset();
        src[0] = mk(2'd3, 1'b1, 32'hA0);
        src[1] = mk(2'd1, 1'b1, 32'hB1);
        step();
        out_Ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t4holdData", 64'({out_SourceIdx, out_Type, out_Data}), 64'({2'd0, 2'd3, 32'hA0}));
            check("t4holdRdy", 64'(src_Ready), 64'd0);
        end
        out_Ready = 1'b1;
        expectReady("t4resumeRdy", 4'b0010);
        step();
        check("t4noBubble", 64'({out_SourceIdx, out_Data}), 64'({2'd1, 32'hB1}));

        // Owner gap mid-packet keeps the lock.
        doReset();
        src[0] = mk(2'd1, 1'b0, 32'h50);
        src[1] = mk(2'd1, 1'b1, 32'h51);
        step();
        for (int k = 0; k < 2; k++) begin
            step();
            check("t5blocked", 64'(src_Ready[1]), 64'd0);
        end
        src[0] = mk(2'd1, 1'b1, 32'h52);
        step(); check("t5resume", 64'({out_SourceIdx, out_Data}), 64'({2'd0, 32'h52}));
        step(); check("t5next", 64'({out_SourceIdx, out_Data}), 64'({2'd1, 32'h51}));

        // Asynchronous reset between edges mid-packet.
        doReset();
        src[0] = mk(2'd1, 1'b0, 32'h60);
        step();
        src[0] = mk(2'd1, 1'b0, 32'h61);
        drive();
        #2;
        rstIn = 1'b1;
        #1;
        check("t6asyncType", 64'(out_Type), 64'd0);
        check("t6asyncRdy", 64'(src_Ready), 64'd0);
        @(negedge clk);
        rstIn = 1'b0;
        modelReset();
        src[0] = mk(2'd1, 1'b1, 32'h70);
        src[3] = mk(2'd1, 1'b1, 32'h73);
        step(); check("t6prio0", 64'({out_SourceIdx, out_Data}), 64'({2'd0, 32'h70}));
        step(); check("t6then3", 64'({out_SourceIdx, out_Data}), 64'({2'd3, 32'h73}));

        // Random traffic with random backpressure.
        doReset();
        for (int c = 0; c < 400; c++) begin
            out_Ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NS; i++) refresh(i);
            step();
            if (lastXfer >= 0) rem[lastXfer]--;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
